mux4_rr_arbiter: RTL
====================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, range 1..15: the maximum number of consecutive cycles one requester may own the grant.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: req[i]=1 means requester i wants the shared MUX_4to1 path.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner finishes its transfer this cycle.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot registered grant, or all zero.
REQ-007 The block SHALL have port sel, output, 2 bits: binary index of the owner, wired to MUX_4to1 sel.
REQ-008 The block SHALL have port valid, output, 1 bit: equal to |gnt.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when the watchdog revokes a grant.

Function
REQ-010 The block SHALL implement two states: IDLE (gnt=0) and BUSY (exactly one gnt bit set).
REQ-011 The block SHALL hold a 2-bit priority pointer ptr; arbitration searches ptr, ptr+1, ptr+2, ptr+3 (mod 4) and picks the first requester with req set.
REQ-012 In IDLE with any req bit set at rising edge N, the block SHALL enter BUSY with the winner's gnt bit set after edge N (one-cycle grant latency).
REQ-013 In IDLE with req=0, the block SHALL remain in IDLE with all outputs unchanged.
REQ-014 The block SHALL keep a 4-bit hold counter, loaded with 1 on every new grant and incremented each BUSY cycle that has no release.
REQ-015 A release SHALL occur at an edge where the block is BUSY and any of these holds: done=1, req[owner]=0, or hold counter equals HOLD_MAX.
REQ-016 On release, ptr SHALL become (owner+1) mod 4.
REQ-017 On release, arbitration SHALL run in the same edge using the new ptr, so the former owner has lowest priority.
- Winner found: gnt moves to the winner back-to-back with no idle cycle; counter reloads to 1.
- No winner: the block enters IDLE.
REQ-018 The former owner SHALL be re-granted immediately only when it is the sole requester.
REQ-019 timeout SHALL be 1 for exactly the cycle after a release caused only by the counter reaching HOLD_MAX with done=0 and req[owner]=1, and 0 otherwise.
REQ-020 When done=1 coincides with the counter reaching HOLD_MAX, the release SHALL count as a normal completion and timeout SHALL stay 0.
REQ-021 sel SHALL update only when a new grant is issued and SHALL hold the last owner's index while in IDLE, so the mux input does not toggle.
REQ-022 done SHALL be ignored while the block is in IDLE.
REQ-023 gnt, sel, valid and timeout SHALL be driven directly from registers, with no combinational path from req or done.
REQ-024 With HOLD_MAX=1, every grant SHALL last exactly one cycle, and timeout SHALL pulse whenever the owner still requests and done=0.

Reset
REQ-025 While rst_n=0, the block SHALL immediately, without waiting for clk, clear the following: state=IDLE, gnt=4'b0000, sel=2'b00, valid=0, timeout=0, ptr=0, counter=0.
REQ-026 When rst_n asserts during BUSY, the grant SHALL be revoked asynchronously and no timeout pulse SHALL follow.
REQ-027 After rst_n deasserts, the first arbitration SHALL use ptr=0.

Verification
REQ-028 Scenario "single requester": req=4'b0100 from reset, done=1 on the 3rd grant cycle -> gnt=4'b0100 and sel=2'b10 one cycle after req, held 3 cycles, then IDLE with sel still 2'b10.
REQ-029 Scenario "rotation": req=4'b1111 held, done pulsed every cycle -> gnt sequence 0001, 0010, 0100, 1000, 0001, with no gaps and valid continuously 1.
REQ-030 Scenario "watchdog": HOLD_MAX=4, req=4'b0011 held, done=0 -> requester 0 is granted 4 cycles, timeout pulses once, requester 1 is granted in the next cycle, then requester 0 after 4 more cycles.
REQ-031 Scenario "done at limit": HOLD_MAX=4, done=1 on the 4th grant cycle -> release occurs and timeout=0.
REQ-032 Scenario "requester drops": owner 2 deasserts req mid-grant while req[3]=1 -> gnt=4'b1000 on the next edge, and ptr makes requester 3 lowest priority after its release.
REQ-033 Scenario "async reset": rst_n pulled low mid-cycle during BUSY with gnt=4'b0010 -> gnt=0, valid=0, sel=0 before the next clk edge; after release, req=4'b1010 grants requester 1 first.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux path: registered one-hot grant,
// binary select, hold-time watchdog with a one-cycle timeout pulse.
module mux4_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       valid,
   output logic       timeout
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   logic [0:0] state;
   logic [1:0] ptr;
   logic [3:0] cnt;

   logic       at_limit;
   logic       rel;
   logic       wd_fire;
   logic       found;
   logic [1:0] base;
   logic [1:0] idx;
   logic [1:0] win;
   logic [3:0] win_oh;

   // sel holds the current owner while BUSY, so it doubles as the owner index.
   always_comb begin
      at_limit = (cnt == HOLD_LIM);
      rel      = (state == BUSY) && (done || !req[sel] || at_limit);
      wd_fire  = (state == BUSY) && at_limit && !done && req[sel];
      // On release the search starts one past the owner, making it lowest priority.
      base     = (state == BUSY) ? sel + 2'd1 : ptr;
      found    = 1'b0;
      idx      = '0;
      win      = base;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = base + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      win_oh = 4'b0001 << win;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= '0;
         sel     <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         timeout <= wd_fire;
         if (state == IDLE) begin
            if (found) begin
               state <= BUSY;
               gnt   <= win_oh;
               sel   <= win;
               valid <= 1'b1;
               cnt   <= 4'd1;
            end
         end else begin
            if (rel) begin
               ptr <= sel + 2'd1;
               if (found) begin
                  gnt   <= win_oh;
                  sel   <= win;
                  valid <= 1'b1;
                  cnt   <= 4'd1;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
                  valid <= 1'b0;
                  cnt   <= '0;
               end
            end else begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

endmodule
